shift_add_mul_core: RTL and testbench
=====================================

Name: shift_add_mul_core

Overview:
- Sequential shift-and-add unsigned multiplier; the compute stage instantiated directly under tt_um_example.
- Top-level wiring: a = ui_in[3:0], b = ui_in[7:4], start = uio_in[0], product drives uo_out.
- Consumes operands from the top-level pins, produces a registered 2*WIDTH-bit product with a one-cycle done pulse.
- Iterative datapath chosen to keep area below the combinational array version.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..8; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  multiplicand (unsigned).
b  input  WIDTH  multiplier (unsigned).
product  output  2*WIDTH  registered result of last completed operation.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; product is valid and new.

Behaviour:
- One clock. Reset is synchronous and active-low on rst_n, sampled at the rising edge of clk.
- Reset (rst_n=0 at an edge), from any state including mid-RUN:
  - state=IDLE; product=0; done=0; busy=0.
  - Internal acc, mcand, mplier and count cleared.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, DONE. Outputs are registered or decoded from state only; no combinational path from the inputs.
- IDLE (busy=0, done=0):
  - On an edge with start=1: mcand <= zero-extended a (2*WIDTH bits), mplier <= b, acc <= 0, count <= 0; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), each edge:
  - If mplier[0]=1, acc <= acc + mcand, truncated to 2*WIDTH bits; this never overflows.
  - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1.
  - On the edge where count = WIDTH-1: product <= final acc value (including this cycle's add); go to DONE.
  - RUN therefore lasts exactly WIDTH cycles, with no early exit when mplier reaches 0.
- DONE (busy=1, done=1): lasts exactly one cycle, then IDLE.
- start is ignored in RUN and DONE. It is not queued, and a and b are not re-sampled.
- Operands are captured only at the accepting edge; changes to a and b during RUN have no effect.
- Latency:
  - start sampled at edge E → done=1 in the cycle following edge E+WIDTH, and product updates at that same edge.
  - Earliest next accept is edge E+WIDTH+2, giving a throughput of WIDTH+2 cycles per operation.
- product holds its value until the next completion or reset. It does not change when a new operation starts.
- start held high continuously → back-to-back operations, one every WIDTH+2 cycles, with operands sampled at each accept edge.
- Zero operands take the full WIDTH cycles; the result is 0.
- Counter width is $clog2(WIDTH), minimum 1.

Test Plan:
- Reset then idle (rst_n=0 for 2 cycles, start=0) → product=0x00, busy=0, done=0 for 10 cycles.
- a=3, b=5, start pulse 1 cycle → busy=1 for 5 cycles, done pulse in cycle 5 after accept, product=15 (0x0F), which then holds.
- a=15, b=15 → product=225 (0xE1); a=0, b=9 → product=0 with the same latency (done 4 cycles after the accept edge).
- Accept a=7, b=6; while busy, assert start with a=2, b=8 and change a/b mid-RUN → result 42 (0x2A); the second request is ignored with no extra done pulse.
- start held high with a=7, b=6, then a=2, b=8 presented after the first accept → product=42 then 16, with done pulses exactly 6 cycles apart.
- rst_n=0 for one edge during the 2nd RUN cycle of a=9, b=9 → next cycle product=0, busy=0, done=0; no done pulse follows; a new request a=9, b=9 then yields 81 (0x51).

Source files
------------

// File: rtl/shift_add_mul_core.sv
// Iterative unsigned shift-and-add multiplier: one partial product per cycle, WIDTH RUN cycles then a one-cycle DONE.
// Result lands WIDTH edges after the accepting edge; start is ignored while busy (no queuing, no backpressure beyond busy).
module shift_add_mul_core #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [2*WIDTH-1:0]  r_acc;
  logic [2*WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]    r_mplier;
  logic [CW-1:0]       r_count;
  logic [2*WIDTH-1:0]  r_product;
  logic                r_busy;
  logic                r_done;
  logic [2*WIDTH-1:0]  w_acc_nxt;

  // Partial products never exceed a*b < 2^(2*WIDTH), so truncation is lossless.
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_busy   <= 1'b0;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          // Fixed WIDTH iterations even when the multiplier runs out of ones.
          if (r_count == LAST) begin
            r_product <= w_acc_nxt;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign product = r_product;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_shift_add_mul_core.sv
// Bench for shift_add_mul_core: directed scenarios then random traffic, every cycle compared
// against a transaction-level model (product = a*b, fixed completion delay, single outstanding op).
module tb_shift_add_mul_core;

  localparam int WIDTH = 4;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  int total = 0;
  int bad   = 0;

  // Model: cycles elapsed since the accept (0 = idle), pending result, visible result.
  int                 m_phase = 0;
  logic [2*WIDTH-1:0] m_pend  = '0;
  logic [2*WIDTH-1:0] m_prod  = '0;

  shift_add_mul_core #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after a rising edge, while the inputs still hold the values that edge saw.
  task automatic model_edge();
    if (!rst_n) begin
      m_phase = 0;
      m_prod  = '0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_pend  = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        m_phase = 1;
      end
    end else if (m_phase == WIDTH) begin
      m_prod  = m_pend;
      m_phase = WIDTH + 1;
    end else if (m_phase == WIDTH + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("product", 64'(product), 64'(m_prod));
    chk("busy",    64'(busy),    64'(m_phase != 0));
    chk("done",    64'(done),    64'(m_phase == WIDTH + 1));
  endtask

  task automatic pulse_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    a = av; b = bv; start = 1'b1;
    step();
    start = 1'b0;
    repeat (WIDTH + 2) step();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;

    // Reset, then idle
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();

    // Single operations, including a zero operand
    pulse_op(4'd3, 4'd5);
    pulse_op(4'd15, 4'd15);
    pulse_op(4'd0, 4'd9);

    // Start re-asserted and operands changed while busy: must be ignored
    a = 4'd7; b = 4'd6; start = 1'b1;
    step();
    a = 4'd2; b = 4'd8;
    step();
    a = 4'd11; b = 4'd13;
    step();
    start = 1'b0; a = 4'd1; b = 4'd1;
    repeat (6) step();

    // Start held high: back-to-back operations every WIDTH+2 cycles
    a = 4'd7; b = 4'd6; start = 1'b1;
    step();
    a = 4'd2; b = 4'd8;
    repeat (12) step();
    start = 1'b0;
    repeat (8) step();

    // Reset during the second RUN cycle discards the operation
    a = 4'd9; b = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (8) step();
    pulse_op(4'd9, 4'd9);

    // Random traffic with operand churn and occasional resets
    repeat (400) begin
      start = ($urandom_range(0, 3) == 0);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      rst_n = ($urandom_range(0, 50) != 0);
      step();
    end
    rst_n = 1'b1; start = 1'b0;
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
